exec_wb_unit: RTL and testbench

Multi-cycle execute/writeback stage of the CPU; sits directly downstream of the register file.
- Consumes the latched operands reg1, reg2 and sp.
- Performs the ALU operation or the stack push/pop, including the data-memory handshake.
- Drives the register-file write controls: rf_we, wa, dr2, sp_we, next_sp.
- Maintains the architectural flags ZF, SF, CF, OF.

---
 rtl/exec_pkg.sv | 35 +++
 rtl/exec_wb_unit_alu.sv | 104 ++++++++++
 rtl/exec_wb_unit.sv | 170 +++++++++++++++++
 tb/tb_exec_wb_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the execute/writeback stage: op code constants,
// FSM state encoding, flag bit positions inside the {OF,CF,SF,ZF} vector and
// the register index that aliases the stack pointer.
// ---------------------------------------------------------------------------
package exec_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_CMP  = 4'd5;
   localparam logic [3:0] OP_MOV  = 4'd6;
   localparam logic [3:0] OP_INC  = 4'd7;
   localparam logic [3:0] OP_DEC  = 4'd8;
   localparam logic [3:0] OP_PUSH = 4'd9;
   localparam logic [3:0] OP_POP  = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MEM  = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   localparam int FLAG_ZF = 0;
   localparam int FLAG_SF = 1;
   localparam int FLAG_CF = 2;
   localparam int FLAG_OF = 3;

   localparam int SP_IDX = 4;

endpackage

// File: rtl/exec_wb_unit_alu.sv
// ---------------------------------------------------------------------------
// exec_alu
// Purely combinational result and flag computation.
//   op        : operation code (exec_pkg constants)
//   a, b      : destination operand and selected source operand
//   cf_in     : current CF, passed through for INC/DEC which keep carry
//   res       : operation result
//   flags_nxt : candidate {OF,CF,SF,ZF}
//   flags_upd : 1 when the op architecturally updates the flags
//   res_we    : 1 when the result is written back to the register file
// PUSH/POP and undefined codes yield no flag update and no result write;
// the stage controller handles the stack side itself.
// ---------------------------------------------------------------------------
module exec_alu
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            cf_in,
   output logic [XLEN-1:0] res,
   output logic [3:0]      flags_nxt,
   output logic            flags_upd,
   output logic            res_we
);

   localparam int M = XLEN - 1;

   logic [XLEN:0] add_w;
   logic [XLEN:0] sub_w;
   logic          cf;
   logic          of;

   always_comb begin
      add_w     = {1'b0, a} + {1'b0, b};
      // Top bit of the widened difference is the unsigned borrow.
      sub_w     = {1'b0, a} - {1'b0, b};
      res       = b;
      cf        = cf_in;
      of        = 1'b0;
      flags_upd = 1'b0;
      res_we    = 1'b0;
      case (op)
         OP_ADD: begin
            res       = add_w[M:0];
            cf        = add_w[XLEN];
            of        = (a[M] == b[M]) && (res[M] != a[M]);
            flags_upd = 1'b1;
            res_we    = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            res       = sub_w[M:0];
            cf        = sub_w[XLEN];
            of        = (a[M] != b[M]) && (res[M] != a[M]);
            flags_upd = 1'b1;
            res_we    = (op == OP_SUB);
         end
         OP_AND: begin
            res       = a & b;
            cf        = 1'b0;
            flags_upd = 1'b1;
            res_we    = 1'b1;
         end
         OP_OR: begin
            res       = a | b;
            cf        = 1'b0;
            flags_upd = 1'b1;
            res_we    = 1'b1;
         end
         OP_XOR: begin
            res       = a ^ b;
            cf        = 1'b0;
            flags_upd = 1'b1;
            res_we    = 1'b1;
         end
         OP_MOV: begin
            res    = b;
            res_we = 1'b1;
         end
         OP_INC: begin
            // CF deliberately left at cf_in.
            res       = a + XLEN'(1);
            of        = ~a[M] & res[M];
            flags_upd = 1'b1;
            res_we    = 1'b1;
         end
         OP_DEC: begin
            res       = a - XLEN'(1);
            of        = a[M] & ~res[M];
            flags_upd = 1'b1;
            res_we    = 1'b1;
         end
         default: ;
      endcase
      flags_nxt          = 4'b0;
      flags_nxt[FLAG_OF] = of;
      flags_nxt[FLAG_CF] = cf;
      flags_nxt[FLAG_SF] = res[M];
      flags_nxt[FLAG_ZF] = ~|res;
   end

endmodule

// File: rtl/exec_wb_unit.sv
// ---------------------------------------------------------------------------
// exec_wb_unit
// Multi-cycle execute/writeback stage. A one-cycle start captures the
// operands; EXEC computes the result and flags; PUSH/POP run a held
// request/ack memory handshake in MEM; WB pulses the register-file write
// strobes and done for one cycle.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, op, dst, use_imm,
//   imm, reg1, reg2, sp      : request and operands (sampled in IDLE only)
//   mem_req/we/addr/wdata    : data-memory request, held until mem_ack
//   mem_ack, mem_rdata       : memory completion and pop data
//   rf_we, wa, dr2           : register write strobe, address, data
//   sp_we, next_sp           : stack pointer write strobe and value
//   busy, done, flags        : status, completion pulse, {OF,CF,SF,ZF}
// ---------------------------------------------------------------------------
module exec_wb_unit
   import exec_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RA_W    = 3,
   parameter int SP_STEP = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [RA_W-1:0] dst,
   input  logic            use_imm,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] reg1,
   input  logic [XLEN-1:0] reg2,
   input  logic [XLEN-1:0] sp,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_we,
   output logic [RA_W-1:0] wa,
   output logic [XLEN-1:0] dr2,
   output logic            sp_we,
   output logic [XLEN-1:0] next_sp,
   output logic            busy,
   output logic            done,
   output logic [3:0]      flags
);

   state_t state, state_nxt;

   // Captured request
   logic [3:0]      op_q;
   logic [RA_W-1:0] dst_q;
   logic            use_imm_q;
   logic [XLEN-1:0] imm_q, reg1_q, reg2_q, sp_q;

   // Write enables decided in EXEC, released as strobes in WB
   logic rf_en_q, sp_en_q;

   logic [XLEN-1:0] src;
   logic [XLEN-1:0] alu_res;
   logic [3:0]      alu_flags;
   logic            alu_flags_upd;
   logic            alu_res_we;
   logic            is_push, is_pop, dst_is_sp;

   assign src       = use_imm_q ? imm_q : reg2_q;
   assign is_push   = (op_q == OP_PUSH);
   assign is_pop    = (op_q == OP_POP);
   assign dst_is_sp = (dst_q == RA_W'(SP_IDX));

   exec_alu #(.XLEN(XLEN)) u_alu (
      .op        (op_q),
      .a         (reg1_q),
      .b         (src),
      .cf_in     (flags[FLAG_CF]),
      .res       (alu_res),
      .flags_nxt (alu_flags),
      .flags_upd (alu_flags_upd),
      .res_we    (alu_res_we)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_EXEC;
         ST_EXEC: state_nxt = (is_push || is_pop) ? ST_MEM : ST_WB;
         ST_MEM:  if (mem_ack) state_nxt = ST_WB;
         ST_WB:   state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Strobes derive from state so a reset returns them to 0 on the very next
   // edge, which is what makes a mid-transaction abort write-free.
   assign mem_req = (state == ST_MEM);
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_WB);
   assign rf_we   = (state == ST_WB) && rf_en_q;
   assign sp_we   = (state == ST_WB) && sp_en_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= '0;
         dst_q     <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         reg1_q    <= '0;
         reg2_q    <= '0;
         sp_q      <= '0;
         rf_en_q   <= 1'b0;
         sp_en_q   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wa        <= '0;
         dr2       <= '0;
         next_sp   <= '0;
         flags     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q      <= op;
                  dst_q     <= dst;
                  use_imm_q <= use_imm;
                  imm_q     <= imm;
                  reg1_q    <= reg1;
                  reg2_q    <= reg2;
                  sp_q      <= sp;
               end
            end
            ST_EXEC: begin
               wa      <= dst_q;
               rf_en_q <= 1'b0;
               sp_en_q <= 1'b0;
               if (alu_flags_upd) flags <= alu_flags;
               if (is_push) begin
                  mem_addr  <= sp_q - XLEN'(SP_STEP);
                  mem_we    <= 1'b1;
                  mem_wdata <= src;
                  next_sp   <= sp_q - XLEN'(SP_STEP);
                  sp_en_q   <= 1'b1;
               end else if (is_pop) begin
                  mem_addr  <= sp_q;
                  mem_we    <= 1'b0;
                  next_sp   <= sp_q + XLEN'(SP_STEP);
                  sp_en_q   <= 1'b1;
                  // Popping into the SP register replaces the SP instead.
                  rf_en_q   <= ~dst_is_sp;
               end else begin
                  dr2     <= alu_res;
                  rf_en_q <= alu_res_we;
               end
            end
            ST_MEM: begin
               if (mem_ack && is_pop) begin
                  dr2 <= mem_rdata;
                  if (dst_is_sp) next_sp <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_wb_unit.sv
module tb_exec_wb_unit;
   import exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  op;
   logic [2:0]  dst;
   logic        use_imm;
   logic [31:0] imm, reg1, reg2, sp;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        rf_we;
   logic [2:0]  wa;
   logic [31:0] dr2;
   logic        sp_we;
   logic [31:0] next_sp;
   logic        busy, done;
   logic [3:0]  flags;

   always #5 clk = ~clk;

   exec_wb_unit #(.XLEN(32), .RA_W(3), .SP_STEP(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst),
      .use_imm(use_imm), .imm(imm), .reg1(reg1), .reg2(reg2), .sp(sp),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .wa(wa), .dr2(dr2), .sp_we(sp_we), .next_sp(next_sp),
      .busy(busy), .done(done), .flags(flags)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Architectural flags as the model sees them, {OF,CF,SF,ZF}
   logic [3:0] mflags = 4'b0;

   // Per-cycle expectations, set by the driver, checked at negedge
   bit          chk_on = 0;
   logic        e_busy, e_done, e_rf, e_sp, e_mreq, e_mwe;
   logic [31:0] e_maddr, e_mwdata, e_dr2, e_nsp;
   logic [2:0]  e_wa;
   logic [3:0]  e_flags;

   // Values observed at the last done, used to pin the model with literals
   logic [31:0] last_dr2, last_nsp;
   logic        last_rf, last_sp;
   logic [3:0]  last_flags;
   int          mreq_cnt;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", busy, e_busy);
         chk("done", done, e_done);
         chk("rf_we", rf_we, e_rf);
         chk("sp_we", sp_we, e_sp);
         chk("mem_req", mem_req, e_mreq);
         chk("flags", flags, e_flags);
         if (e_mreq) begin
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_we", mem_we, e_mwe);
            if (e_mwe) chk("mem_wdata", mem_wdata, e_mwdata);
         end
         if (e_rf) begin
            chk("wa", wa, e_wa);
            chk("dr2", dr2, e_dr2);
         end
         if (e_sp) chk("next_sp", next_sp, e_nsp);
         if (mem_req) mreq_cnt++;
         if (done) begin
            last_dr2   = dr2;
            last_nsp   = next_sp;
            last_rf    = rf_we;
            last_sp    = sp_we;
            last_flags = flags;
         end
      end
   end

   function automatic bit ovf(input longint v);
      return (v > 64'sd2147483647) || (v < -64'sd2147483648);
   endfunction

   // Reference semantics written as plain integer arithmetic.
   function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [3:0] f, output logic [31:0] r, output bit wr);
      longint sa, sb;
      bit upd, cf, of;
      sa = $signed(a);
      sb = $signed(b);
      upd = 1; cf = f[2]; of = 0; wr = 0; r = 0;
      case (o)
         OP_ADD: begin r = a + b; cf = (longint'(a) + longint'(b)) > 64'sd4294967295; of = ovf(sa + sb); wr = 1; end
         OP_SUB: begin r = a - b; cf = a < b; of = ovf(sa - sb); wr = 1; end
         OP_CMP: begin r = a - b; cf = a < b; of = ovf(sa - sb); end
         OP_AND: begin r = a & b; cf = 0; wr = 1; end
         OP_OR:  begin r = a | b; cf = 0; wr = 1; end
         OP_XOR: begin r = a ^ b; cf = 0; wr = 1; end
         OP_MOV: begin r = b; wr = 1; upd = 0; end
         OP_INC: begin r = a + 1; of = ovf(sa + 1); wr = 1; end
         OP_DEC: begin r = a - 1; of = ovf(sa - 1); wr = 1; end
         default: upd = 0;
      endcase
      if (upd) f = {of, cf, r[31], r == 32'd0};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_inputs();
      start = 1'($urandom_range(0, 1));
      op = 4'($urandom); dst = 3'($urandom); use_imm = 1'($urandom);
      imm = $urandom; reg1 = $urandom; reg2 = $urandom; sp = $urandom;
   endtask

   // One full transaction: request cycle, EXEC, W wait + 1 ack MEM cycles
   // for stack ops, WB, then one idle cycle.
   task automatic run_op(input logic [3:0] o, input logic [2:0] d, input bit ui,
                         input logic [31:0] im, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] s, input int w, input logic [31:0] rd);
      logic [31:0] src, res;
      bit wr;
      src = ui ? im : r2;
      last_dr2 = 32'hA5A5A5A5; last_nsp = 32'hA5A5A5A5; last_rf = 1'b1; last_sp = 1'b0;
      last_flags = 4'hF; mreq_cnt = 0;
      start = 1; op = o; dst = d; use_imm = ui; imm = im; reg1 = r1; reg2 = r2; sp = s;
      mem_ack = 0;
      e_busy = 0; e_done = 0; e_rf = 0; e_sp = 0; e_mreq = 0; e_mwe = 0; e_flags = mflags;
      step();
      junk_inputs();
      e_busy = 1;
      model(o, r1, src, mflags, res, wr);
      step();
      e_flags = mflags;
      if (o == OP_PUSH || o == OP_POP) begin
         e_mreq = 1; e_mwe = (o == OP_PUSH);
         e_maddr = (o == OP_PUSH) ? s - 32'd4 : s;
         e_mwdata = src;
         for (int i = 0; i <= w; i++) begin
            junk_inputs();
            mem_ack = (i == w);
            mem_rdata = (i == w) ? rd : $urandom;
            step();
         end
         mem_ack = 0; e_mreq = 0;
      end
      junk_inputs();
      e_done = 1;
      if (o == OP_PUSH) begin
         e_sp = 1; e_nsp = s - 32'd4;
      end else if (o == OP_POP) begin
         e_sp = 1;
         if (d == 3'(SP_IDX)) e_nsp = rd;
         else begin e_nsp = s + 32'd4; e_rf = 1; e_wa = d; e_dr2 = rd; end
      end else if (wr) begin
         e_rf = 1; e_wa = d; e_dr2 = res;
      end
      step();
      start = 0;
      e_busy = 0; e_done = 0; e_rf = 0; e_sp = 0;
      step();
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h7FFFFFFF;
         4: return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1; start = 0; op = 0; dst = 0; use_imm = 0; imm = 0; reg1 = 0; reg2 = 0; sp = 0;
      mem_ack = 0; mem_rdata = 0;
      step(); step();
      rst = 0;
      step();
      chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
      chk("rst_mem_req", mem_req, 0); chk("rst_mem_we", mem_we, 0);
      chk("rst_rf_we", rf_we, 0);    chk("rst_sp_we", sp_we, 0);
      chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_dr2", dr2, 0);        chk("rst_next_sp", next_sp, 0);
      chk("rst_wa", wa, 0);          chk("rst_flags", flags, 0);

      chk_on = 1;
      // Directed cases with hand-computed results
      run_op(OP_ADD, 3'd2, 0, 0, 32'h7FFFFFFF, 32'h1, 0, 0, 0);
      chk("pin_add_dr2", last_dr2, 32'h80000000);
      chk("pin_add_flags", last_flags, 4'b1010);
      run_op(OP_SUB, 3'd3, 1, 32'd5, 32'd5, 32'd99, 0, 0, 0);
      chk("pin_sub_dr2", last_dr2, 32'h0);
      chk("pin_sub_flags", last_flags, 4'b0001);
      run_op(OP_CMP, 3'd3, 0, 0, 32'd3, 32'd5, 0, 0, 0);
      chk("pin_cmp_rf_we", last_rf, 0);
      chk("pin_cmp_flags", last_flags, 4'b0110);
      run_op(OP_PUSH, 3'd0, 0, 0, 0, 32'hDEADBEEF, 32'h100, 3, 0);
      chk("pin_push_reqcycles", mreq_cnt, 4);
      chk("pin_push_nsp", last_nsp, 32'hFC);
      run_op(OP_POP, 3'd1, 0, 0, 0, 0, 32'hFC, 0, 32'h1234);
      chk("pin_pop_dr2", last_dr2, 32'h1234);
      chk("pin_pop_nsp", last_nsp, 32'h100);
      run_op(OP_POP, 3'd4, 0, 0, 0, 0, 32'hFC, 0, 32'h1234);
      chk("pin_pop4_rf_we", last_rf, 0);
      chk("pin_pop4_nsp", last_nsp, 32'h1234);
      run_op(OP_INC, 3'd5, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
      chk("pin_inc_dr2", last_dr2, 32'h0);
      chk("pin_inc_flags", last_flags, 4'b0101);
      run_op(OP_PUSH, 3'd0, 1, 32'h55, 0, 0, 32'h0, 1, 0);
      chk("pin_push_wrap", last_nsp, 32'hFFFFFFFC);
      run_op(4'd13, 3'd2, 0, 0, 32'h1, 32'h2, 0, 0, 0);
      chk("pin_undef_rf_we", last_rf, 0);
      chk("pin_undef_sp_we", last_sp, 0);

      // Randomized transactions including undefined codes and wait states
      for (int n = 0; n < 150; n++) begin
         logic [3:0] o;
         o = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) o = ($urandom_range(0, 1) != 0) ? OP_PUSH : OP_POP;
         run_op(o, 3'($urandom), 1'($urandom), pick(), pick(), pick(),
                ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom,
                $urandom_range(0, 3), $urandom);
      end

      // Make sure the flags are non-zero before the abort test
      run_op(OP_CMP, 3'd0, 0, 0, 32'd0, 32'd1, 0, 0, 0);
      chk_on = 0;

      // Reset while waiting for the memory acknowledge
      start = 1; op = OP_PUSH; dst = 0; use_imm = 0; reg2 = 32'h77; sp = 32'h200; mem_ack = 0;
      step();
      start = 0;
      step(); step(); step();
      chk("abort_in_mem", mem_req, 1);
      rst = 1;
      step();
      rst = 0;
      chk("abort_mem_req", mem_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_flags", flags, 0);
      for (int i = 0; i < 6; i++) begin
         mem_ack = (i == 0);
         chk("abort_no_rf_we", rf_we, 0);
         chk("abort_no_sp_we", sp_we, 0);
         chk("abort_no_done", done, 0);
         step();
      end
      mem_ack = 0;
      mflags = 4'b0;

      chk_on = 1;
      run_op(OP_XOR, 3'd6, 0, 0, 32'hF0F0F0F0, 32'hF0F0F0F0, 0, 0, 0);
      chk("pin_xor_flags", last_flags, 4'b0001);
      chk_on = 0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
